// File: rtl/uc_pilha_pkg.sv
// Shared definitions for the stack-machine control unit.
// Holds the opcode map, the FSM state encoding, the fault codes reported on
// err_code, and the operation set understood by the pilha_lifo stack.
package uc_pilha_pkg;

  // Opcode map (values are independent of OP_W; the top casts them).
  localparam int unsigned OPC_PUSH_I    = 0;
  localparam int unsigned OPC_PUSH_M    = 1;
  localparam int unsigned OPC_POP_M     = 2;
  localparam int unsigned OPC_ALU_FIRST = 3;
  localparam int unsigned OPC_ALU_LAST  = 12;
  localparam int unsigned OPC_GOTO      = 13;
  localparam int unsigned OPC_IF_EQ     = 14;
  localparam int unsigned OPC_HALT      = 15;

  // Fault codes latched into err_code when the unit enters ERROR.
  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    STK_NONE     = 3'd0,
    STK_PUSH     = 3'd1,
    STK_POP      = 3'd2,
    STK_POP2     = 3'd3,
    STK_REPLACE2 = 3'd4
  } stack_op_t;

endpackage

// File: rtl/pilha_lifo.sv
// pilha_lifo: DEPTH-entry LIFO used as the operand stack.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-low reset (count only)
//   op            none / push / pop / pop2 / replace2
//   din           data written by push, or the result written by replace2
//   top, next     top entry and the entry below it; 0 when not backed by data
//   count         occupancy 0..DEPTH
//   full, empty   occupancy flags
// Storage is intentionally not reset; only the occupancy counter is.
// Operations that would over/underflow are ignored here; the control unit
// is expected to detect those cases itself and never issue them.
module pilha_lifo
  import uc_pilha_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  stack_op_t                  op,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          top,
  output logic [DATA_W-1:0]          next,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  top_pos;
  logic [CNT_W-1:0]  next_pos;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              has_one;
  logic              has_two;
  logic              do_push;
  logic              do_pop;
  logic              do_pop2;
  logic              do_rep2;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign has_one  = (count >= CNT_W'(1));
  assign has_two  = (count >= CNT_W'(2));
  assign top_pos  = count - CNT_W'(1);
  assign next_pos = count - CNT_W'(2);
  assign top_idx  = top_pos[IDX_W-1:0];
  assign next_idx = next_pos[IDX_W-1:0];
  assign push_idx = count[IDX_W-1:0];

  assign top  = has_one ? mem[top_idx]  : '0;
  assign next = has_two ? mem[next_idx] : '0;

  assign do_push = (op == STK_PUSH) && !full;
  assign do_pop  = (op == STK_POP) && has_one;
  assign do_pop2 = (op == STK_POP2) && has_two;
  assign do_rep2 = (op == STK_REPLACE2) && has_two;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CNT_W'(1);
    end else if (do_pop || do_rep2) begin
      count <= count - CNT_W'(1);
    end else if (do_pop2) begin
      count <= count - CNT_W'(2);
    end
  end

  // Writes are gated by reset so an operation in flight when reset arrives
  // leaves no trace in storage either.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (do_push) begin
        mem[push_idx] <= din;
      end else if (do_rep2) begin
        // replace2 collapses the top two entries into the slot of 'next'
        mem[next_idx] <= din;
      end
    end
  end

endmodule

// File: rtl/uc_pilha_param.sv
// uc_pilha_param: control unit of a small stack machine.
// Each instruction is fetched from a synchronous ROM (FETCH drives a_rom,
// DECODE captures inst), executed in EXEC, and PUSH_M uses an extra WB cycle
// to collect the synchronous RAM read. Faults and HALT park the FSM until
// reset.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-low reset
//   inst                   ROM word {opcode, imm}, valid one cycle after a_rom
//   data_mem               RAM read data, valid one cycle after a_ram
//   alu_result             combinational ALU result for operand_a/b, alu_op
//   a_rom                  program counter
//   a_ram, ram_wren,
//   ram_data               RAM address / write strobe / write data
//   alu_op                 opcode presented to the ALU during EXEC
//   operand_a, operand_b   entry below top / top of stack (0 if absent)
//   sp_count               stack occupancy
//   halted, error,
//   err_code               status; err_code 01 ovf, 10 unf, 11 illegal
//   state_dbg              current FSM state
module uc_pilha_param
  import uc_pilha_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5,
  parameter int DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [OP_W+ADDR_W-1:0]     inst,
  input  logic [DATA_W-1:0]          data_mem,
  input  logic [DATA_W-1:0]          alu_result,
  output logic [ADDR_W-1:0]          a_rom,
  output logic [ADDR_W-1:0]          a_ram,
  output logic                       ram_wren,
  output logic [DATA_W-1:0]          ram_data,
  output logic [OP_W-1:0]            alu_op,
  output logic [DATA_W-1:0]          operand_a,
  output logic [DATA_W-1:0]          operand_b,
  output logic [$clog2(DEPTH+1)-1:0] sp_count,
  output logic                       halted,
  output logic                       error,
  output logic [1:0]                 err_code,
  output state_t                     state_dbg
);

  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [OP_W-1:0] OP_PUSH_I    = OP_W'(OPC_PUSH_I);
  localparam logic [OP_W-1:0] OP_PUSH_M    = OP_W'(OPC_PUSH_M);
  localparam logic [OP_W-1:0] OP_POP_M     = OP_W'(OPC_POP_M);
  localparam logic [OP_W-1:0] OP_ALU_FIRST = OP_W'(OPC_ALU_FIRST);
  localparam logic [OP_W-1:0] OP_ALU_LAST  = OP_W'(OPC_ALU_LAST);
  localparam logic [OP_W-1:0] OP_GOTO      = OP_W'(OPC_GOTO);
  localparam logic [OP_W-1:0] OP_IF_EQ     = OP_W'(OPC_IF_EQ);
  localparam logic [OP_W-1:0] OP_HALT      = OP_W'(OPC_HALT);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [OP_W-1:0]   ir_op;
  logic [ADDR_W-1:0] ir_imm;
  logic [OP_W-1:0]   inst_op;
  logic [ADDR_W-1:0] inst_imm;
  logic              inst_is_alu;
  logic              ir_is_alu;

  stack_op_t         stk_op;
  logic [DATA_W-1:0] stk_din;
  logic [DATA_W-1:0] stk_top;
  logic [DATA_W-1:0] stk_next;
  logic [CNT_W-1:0]  stk_count;
  logic              stk_full;
  logic              stk_empty;

  logic [1:0]        exec_err;
  logic              exec_halt;
  logic              exec_wb;

  assign inst_op     = inst[OP_W+ADDR_W-1:ADDR_W];
  assign inst_imm    = inst[ADDR_W-1:0];
  assign inst_is_alu = (inst_op >= OP_ALU_FIRST) && (inst_op <= OP_ALU_LAST);
  assign ir_is_alu   = (ir_op >= OP_ALU_FIRST) && (ir_op <= OP_ALU_LAST);
  assign pc_inc      = pc + ADDR_W'(1);  // wraps max -> 0

  assign a_rom     = pc;
  assign operand_a = stk_next;
  assign operand_b = stk_top;
  assign sp_count  = stk_count;
  assign state_dbg = state;

  pilha_lifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_pilha (
    .clock (clock),
    .reset (reset),
    .op    (stk_op),
    .din   (stk_din),
    .top   (stk_top),
    .next  (stk_next),
    .count (stk_count),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Execution decisions: stack command, next pc and fault code for the
  // instruction held in the instruction register. Faults leave the stack
  // and pc untouched.
  always_comb begin
    stk_op    = STK_NONE;
    stk_din   = '0;
    exec_err  = ERR_NONE;
    exec_halt = 1'b0;
    exec_wb   = 1'b0;
    pc_next   = pc_inc;
    if (state == ST_EXEC) begin
      if (ir_op == OP_PUSH_I) begin
        if (stk_full) begin
          exec_err = ERR_OVERFLOW;
        end else begin
          stk_op  = STK_PUSH;
          stk_din = DATA_W'(ir_imm);
        end
      end else if (ir_op == OP_PUSH_M) begin
        if (stk_full) exec_err = ERR_OVERFLOW;
        else          exec_wb  = 1'b1;
      end else if (ir_op == OP_POP_M) begin
        if (stk_empty) exec_err = ERR_UNDERFLOW;
        else           stk_op   = STK_POP;
      end else if (ir_is_alu) begin
        if (stk_count < CNT_W'(2)) begin
          exec_err = ERR_UNDERFLOW;
        end else begin
          stk_op  = STK_REPLACE2;
          stk_din = alu_result;
        end
      end else if (ir_op == OP_GOTO) begin
        pc_next = ir_imm;
      end else if (ir_op == OP_IF_EQ) begin
        if (stk_count < CNT_W'(2)) begin
          exec_err = ERR_UNDERFLOW;
        end else begin
          stk_op = STK_POP2;
          if (stk_next == stk_top) pc_next = ir_imm;
        end
      end else if (ir_op == OP_HALT) begin
        exec_halt = 1'b1;
      end else begin
        exec_err = ERR_ILLEGAL;
      end
    end else if (state == ST_WB) begin
      stk_op  = STK_PUSH;
      stk_din = data_mem;
    end
  end

  // Main FSM. RAM/ALU strobes are set up on the DECODE->EXEC edge straight
  // from the ROM word so they are already valid throughout EXEC, and they
  // are dropped again on the way out of EXEC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_FETCH;
      pc       <= '0;
      ir_op    <= '0;
      ir_imm   <= '0;
      a_ram    <= '0;
      ram_wren <= 1'b0;
      ram_data <= '0;
      alu_op   <= '0;
      halted   <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_op  <= inst_op;
          ir_imm <= inst_imm;
          state  <= ST_EXEC;
          if ((inst_op == OP_PUSH_M) || (inst_op == OP_POP_M)) begin
            a_ram <= inst_imm;
          end
          // An underflowing POP_M must not write, so the strobe is
          // qualified by occupancy here rather than in EXEC.
          if ((inst_op == OP_POP_M) && !stk_empty) begin
            ram_wren <= 1'b1;
            ram_data <= stk_top;
          end
          alu_op <= inst_is_alu ? inst_op : '0;
        end
        ST_EXEC: begin
          ram_wren <= 1'b0;
          alu_op   <= '0;
          if (exec_err != ERR_NONE) begin
            state    <= ST_ERROR;
            error    <= 1'b1;
            err_code <= exec_err;
          end else if (exec_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (exec_wb) begin
            state <= ST_WB;
          end else begin
            pc    <= pc_next;
            state <= ST_FETCH;
          end
        end
        ST_WB: begin
          pc    <= pc_inc;
          state <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_pilha_param.sv
module tb_uc_pilha_param;
  import uc_pilha_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 5;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int WR_W   = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [OP_W+ADDR_W-1:0] inst;
  logic [DATA_W-1:0]      data_mem;
  logic [DATA_W-1:0]      alu_result;
  logic [ADDR_W-1:0]      a_rom;
  logic [ADDR_W-1:0]      a_ram;
  logic                   ram_wren;
  logic [DATA_W-1:0]      ram_data;
  logic [OP_W-1:0]        alu_op;
  logic [DATA_W-1:0]      operand_a;
  logic [DATA_W-1:0]      operand_b;
  logic [CNT_W-1:0]       sp_count;
  logic                   halted;
  logic                   error;
  logic [1:0]             err_code;
  state_t                 state_dbg;

  uc_pilha_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .inst       (inst),
    .data_mem   (data_mem),
    .alu_result (alu_result),
    .a_rom      (a_rom),
    .a_ram      (a_ram),
    .ram_wren   (ram_wren),
    .ram_data   (ram_data),
    .alu_op     (alu_op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .sp_count   (sp_count),
    .halted     (halted),
    .error      (error),
    .err_code   (err_code),
    .state_dbg  (state_dbg)
  );

  // ---------------- environment: ROM, RAM, ALU ----------------
  logic [OP_W+ADDR_W-1:0] rom [32];
  logic [DATA_W-1:0]      ram [32];

  function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      5'd3:    return a + b;
      5'd4:    return a - b;
      5'd5:    return a & b;
      5'd6:    return a | b;
      5'd7:    return a ^ b;
      5'd8:    return ~(a & b);
      5'd9:    return (a > b) ? a : b;
      5'd10:   return (a < b) ? 16'd1 : 16'd0;
      5'd11:   return a << b[3:0];
      5'd12:   return a * b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, operand_a, operand_b);

  always @(posedge clock) begin
    inst     <= rom[a_rom];
    data_mem <= ram[a_ram];
    if (ram_wren) ram[a_ram] <= ram_data;
  end

  // ---------------- scoreboard state ----------------
  int    n_asserts = 0;
  int    n_fail    = 0;
  string cur_prog  = "init";
  logic [WR_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_prog, tag, obs, exp);
    end
  endtask

  // Every RAM write must match the next one the model predicted.
  always @(negedge clock) begin
    if (reset && ram_wren) begin
      n_asserts++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL %s/ram_write: observed write a=%0d d=%0h expected no write",
               cur_prog, a_ram, ram_data);
      end
      if (exp_q.size() != 0) check("ram_write", 32'({a_ram, ram_data}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- instruction-level reference model ----------------
  logic [ADDR_W-1:0] m_pc;
  logic [DATA_W-1:0] m_stk [$];
  logic [DATA_W-1:0] mram [32];
  logic              m_halted;
  logic [1:0]        m_err;

  task automatic model_step(output int cyc);
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] imm;
    logic [DATA_W-1:0] a, b;
    op  = rom[m_pc][OP_W+ADDR_W-1:ADDR_W];
    imm = rom[m_pc][ADDR_W-1:0];
    cyc = 3;
    if (op == 5'd0 || op == 5'd1) begin
      if (m_stk.size() == DEPTH) begin
        m_err = 2'b01;
      end else begin
        if (op == 5'd0) begin
          m_stk.push_back(DATA_W'(imm));
        end else begin
          m_stk.push_back(mram[imm]);
          cyc = 4;
        end
        m_pc = m_pc + 5'd1;
      end
    end else if (op == 5'd2) begin
      if (m_stk.size() < 1) begin
        m_err = 2'b10;
      end else begin
        b = m_stk.pop_back();
        mram[imm] = b;
        exp_q.push_back({imm, b});
        m_pc = m_pc + 5'd1;
      end
    end else if (op >= 5'd3 && op <= 5'd12) begin
      if (m_stk.size() < 2) begin
        m_err = 2'b10;
      end else begin
        b = m_stk.pop_back();
        a = m_stk.pop_back();
        m_stk.push_back(alu_fn(op, a, b));
        m_pc = m_pc + 5'd1;
      end
    end else if (op == 5'd13) begin
      m_pc = imm;
    end else if (op == 5'd14) begin
      if (m_stk.size() < 2) begin
        m_err = 2'b10;
      end else begin
        b = m_stk.pop_back();
        a = m_stk.pop_back();
        m_pc = (a == b) ? imm : m_pc + 5'd1;
      end
    end else if (op == 5'd15) begin
      m_halted = 1'b1;
    end else begin
      m_err = 2'b11;
    end
  endtask

  task automatic check_arch();
    state_t exp_st;
    logic [DATA_W-1:0] exp_b, exp_a;
    exp_st = m_halted ? ST_HALT : (m_err != 2'b00) ? ST_ERROR : ST_FETCH;
    exp_b  = (m_stk.size() >= 1) ? m_stk[m_stk.size()-1] : '0;
    exp_a  = (m_stk.size() >= 2) ? m_stk[m_stk.size()-2] : '0;
    check("state",     32'(state_dbg), 32'(exp_st));
    check("a_rom",     32'(a_rom),     32'(m_pc));
    check("sp_count",  32'(sp_count),  32'(m_stk.size()));
    check("operand_b", 32'(operand_b), 32'(exp_b));
    check("operand_a", 32'(operand_a), 32'(exp_a));
    check("halted",    32'(halted),    32'(m_halted));
    check("error",     32'(error),     32'(m_err != 2'b00));
    check("err_code",  32'(err_code),  32'(m_err));
    check("ram_wren",  32'(ram_wren),  32'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = {5'd15, 5'd0};
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    m_pc = '0;
    m_stk.delete();
    m_halted = 1'b0;
    m_err = 2'b00;
    exp_q.delete();
    check("rst_state",    32'(state_dbg), 32'(ST_FETCH));
    check("rst_a_rom",    32'(a_rom),     32'(0));
    check("rst_sp_count", 32'(sp_count),  32'(0));
    check("rst_a_ram",    32'(a_ram),     32'(0));
    check("rst_ram_data", 32'(ram_data),  32'(0));
    check("rst_alu_op",   32'(alu_op),    32'(0));
    check("rst_operands", 32'({operand_a, operand_b}), 32'(0));
    check("rst_status",   32'({halted, error, err_code}), 32'(0));
  endtask

  task automatic run_prog(input string name, input int max_instr);
    int cyc;
    cur_prog = name;
    do_reset();
    for (int n = 0; n < max_instr && !m_halted && m_err == 2'b00; n++) begin
      model_step(cyc);
      repeat (cyc) @(negedge clock);
      check_arch();
    end
    if (m_halted) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        check("halt_a_rom",  32'(a_rom),  32'(m_pc));
        check("halt_halted", 32'(halted), 32'(1));
      end
    end
    check("pending_writes", 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [OP_W-1:0] rop;
    int r;
    for (int i = 0; i < 32; i++) begin
      ram[i]  = DATA_W'($urandom);
      mram[i] = ram[i];
    end

    // PUSH_I 5, PUSH_I 3, ALU(3), POP_M 7, HALT
    clear_rom();
    rom[0] = {5'd0, 5'd5};
    rom[1] = {5'd0, 5'd3};
    rom[2] = {5'd3, 5'd0};
    rom[3] = {5'd2, 5'd7};
    run_prog("alu_pop", 10);
    check("alu_pop_ram7", 32'(ram[7]), 32'(16'd8));

    // IF_EQ taken and not taken
    clear_rom();
    rom[0] = {5'd0, 5'd4};
    rom[1] = {5'd0, 5'd4};
    rom[2] = {5'd14, 5'd20};
    run_prog("if_eq_taken", 3);
    check("if_eq_taken_pc", 32'(a_rom), 32'(20));
    rom[1] = {5'd0, 5'd5};
    run_prog("if_eq_not_taken", 3);
    check("if_eq_not_taken_pc", 32'(a_rom), 32'(3));

    // overflow on the 17th push
    clear_rom();
    for (int i = 0; i < 17; i++) rom[i] = {5'd0, 5'(i)};
    run_prog("overflow", 17);
    check("overflow_code", 32'({error, err_code, sp_count}), 32'({1'b1, 2'b01, 5'd16}));

    // underflow and illegal opcode
    clear_rom();
    rom[0] = {5'd2, 5'd4};
    run_prog("pop_empty", 2);
    check("pop_empty_code", 32'(err_code), 32'(2'b10));
    rom[0] = {5'd20, 5'd1};
    run_prog("illegal", 2);
    check("illegal_code", 32'(err_code), 32'(2'b11));

    // pc wrap 31 -> 0
    clear_rom();
    rom[0]  = {5'd13, 5'd31};
    rom[31] = {5'd0, 5'd9};
    run_prog("goto_wrap", 5);

    // PUSH_M path
    clear_rom();
    rom[0] = {5'd1, 5'd2};
    rom[1] = {5'd1, 5'd3};
    rom[2] = {5'd4, 5'd0};
    rom[3] = {5'd2, 5'd9};
    run_prog("push_m", 10);

    // reset during PUSH_M write-back
    clear_rom();
    rom[0] = {5'd1, 5'd2};
    cur_prog = "reset_in_wb";
    do_reset();
    repeat (3) @(negedge clock);
    check("in_wb", 32'(state_dbg), 32'(ST_WB));
    reset = 1'b0;
    @(negedge clock);
    check("wb_rst_state", 32'(state_dbg), 32'(ST_FETCH));
    check("wb_rst_a_rom", 32'(a_rom),     32'(0));
    check("wb_rst_sp",    32'(sp_count),  32'(0));
    reset = 1'b1;
    @(negedge clock);
    check("wb_rst_no_push", 32'(sp_count), 32'(0));

    // randomized programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 32; i++) begin
        r = $urandom_range(0, 99);
        if (i < 2 || r < 30)  rop = 5'd0;
        else if (r < 42)      rop = 5'd1;
        else if (r < 55)      rop = 5'd2;
        else if (r < 80)      rop = 5'($urandom_range(3, 12));
        else if (r < 90)      rop = 5'd14;
        else if (r < 93)      rop = 5'd13;
        else if (r < 96)      rop = 5'd15;
        else                  rop = 5'($urandom_range(16, 31));
        rom[i] = {rop, 5'($urandom_range(0, 31))};
      end
      run_prog($sformatf("random%0d", p), 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uc_pilha_param.md
UC_PILHA_PARAM -- requirements
Module: uc_pilha_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning stack, RAM and ALU data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning ROM/RAM address width and immediate width.
REQ-003 SHALL have parameter OP_W, default 5, meaning opcode width; inst width = OP_W+ADDR_W.
REQ-004 SHALL have parameter DEPTH, default 16, meaning internal stack entries (>=2).
REQ-005 SHALL have one clock; reset is synchronous and active-low; ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- inst  in  OP_W+ADDR_W  ROM word, {opcode, imm}, valid one cycle after a_rom.
- data_mem  in  DATA_W  RAM read data, valid one cycle after a_ram.
- alu_result  in  DATA_W  combinational ALU result for operand_a/operand_b/alu_op.
- a_rom  out  ADDR_W  program counter.
- a_ram  out  ADDR_W  RAM address.
- ram_wren  out  1  RAM write strobe.
- ram_data  out  DATA_W  RAM write data.
- alu_op  out  OP_W  opcode passed to ALU.
- operand_a  out  DATA_W  stack entry below top (0 if count<2).
- operand_b  out  DATA_W  stack top (0 if count<1).
- sp_count  out  clog2(DEPTH+1)  stack occupancy.
- halted  out  1  HALT executed.
- error  out  1  fault latched.
- err_code  out  2  01 overflow, 10 underflow, 11 illegal opcode, 00 none.

Function
REQ-006 SHALL implement FSM states FETCH, DECODE, EXEC, WB, HALT, ERROR; FETCH->DECODE->EXEC always.
REQ-007 FETCH SHALL drive a_rom=pc; DECODE SHALL latch inst into instruction register; EXEC acts on it.
REQ-008 Opcodes: 0 PUSH_I, 1 PUSH_M, 2 POP_M, 3-12 ALU class, 13 GOTO, 14 IF_EQ, 15 HALT; >=16 illegal.
REQ-009 PUSH_I SHALL push zero-extended imm in EXEC; 3 cycles; pc+1.
REQ-010 PUSH_M SHALL drive a_ram=imm in EXEC, push data_mem in WB; 4 cycles; pc+1.
REQ-011 POP_M SHALL assert ram_wren one cycle in EXEC with a_ram=imm, ram_data=top, and pop; 3 cycles.
REQ-012 ALU class SHALL drive alu_op=opcode in EXEC and replace top two entries with alu_result (count-1); 3 cycles.
REQ-013 GOTO SHALL set pc=imm; IF_EQ SHALL pop two and set pc=imm if equal, else pc+1; 3 cycles.
REQ-014 HALT SHALL enter HALT, assert halted, hold all outputs until reset.
REQ-015 pc increment SHALL wrap modulo 2^ADDR_W (max -> 0).
REQ-016 Push at count==DEPTH SHALL not modify stack, set err_code=01, enter ERROR.
REQ-017 Pop/ALU/IF_EQ with insufficient entries SHALL not modify stack or pc, set err_code=10, enter ERROR.
REQ-018 Illegal opcode SHALL set err_code=11, enter ERROR; ERROR holds error=1 until reset.
REQ-019 ram_wren SHALL be 0 in every state except POP_M EXEC.

Reset
REQ-020 reset low at rising edge SHALL, mid-instruction or not, force FETCH, pc=0, sp_count=0, a_ram=0, ram_wren=0, ram_data=0, alu_op=0, halted=0, error=0, err_code=00.
REQ-021 Stack storage SHALL not be reset; operand_a/operand_b SHALL read 0 when not backed by valid entries.

Structure
REQ-022 Opcode constants, state encoding and err_code constants SHALL live in shared package uc_pilha_pkg.
REQ-023 Stack SHALL be sub-module pilha_lifo (ops none/push/pop/pop2/replace2; outputs top, next, count, full, empty).

Verification
REQ-024 PUSH_I 5, PUSH_I 3, ALU(3), POP_M 7 -> ram_wren once, a_ram=7, ram_data=alu_result for (3,5); sp_count 0.
REQ-025 PUSH_I 4, PUSH_I 4, IF_EQ 20 -> a_rom=20 at next FETCH; repeat with 4,5 -> a_rom=3.
REQ-026 DEPTH=16: 16 PUSH_I then 17th -> error=1, err_code=01, sp_count=16.
REQ-027 POP_M on empty stack -> err_code=10, ram_wren never asserted; opcode 20 -> err_code=11.
REQ-028 GOTO 31 then NOP-free run -> pc wraps 31->0; HALT -> halted=1, a_rom frozen 10 cycles.
REQ-029 reset low during PUSH_M WB -> next edge FETCH, a_rom=0, sp_count=0, no push.
